bus_grant_arbiter: RTL

//   Round-robin arbiter that shares the 32-bit internal bus between up to 24 drivers
//   (r0-r15, hi, lo, zhi, zlo, pc, mdr, inport, c_sign_extended).

---
 rtl/bus_grant_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bus_grant_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_grant_arbiter : round-robin owner arbiter for the shared 32-bit bus;  |
// | optional forced revoke after MAX_HOLD cycles when BUS_ARB_TIMEOUT_EN set. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module bus_grant_arbiter #(
  parameter int NUM_REQ  = 24,
  parameter int SEL_W    = 5
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
`endif
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_release,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SEL_W-1:0]   o_select_signal,
  output logic               o_bus_busy,
  output logic               o_timeout_flag
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]         r_state;
  logic [c_IDX_W-1:0] r_owner;
  logic [c_IDX_W-1:0] r_rr_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic               r_busy;

  logic               w_owner_req;
  logic               w_end;
  logic               w_timeout;
  logic               w_drop;
  logic [c_IDX_W-1:0] w_next_ptr;
  logic [c_IDX_W-1:0] w_base;
  logic [NUM_REQ-1:0] w_req_m;
  logic               w_found;
  logic [c_IDX_W-1:0] w_win;

  // r_grant is one-hot on the owner, so this picks out req[owner] without a wide index
  assign w_owner_req = |(i_req & r_grant);
  assign w_end       = (r_state == S_GRANT) && (i_release || !w_owner_req);
  assign w_drop      = w_end || w_timeout;
  assign w_next_ptr  = (r_owner == c_LAST_IDX) ? '0 : r_owner + c_IDX_W'(1);

  // While granted, re-arbitrate from the post-release pointer with the owner masked out
  assign w_base  = (r_state == S_GRANT) ? w_next_ptr : r_rr_ptr;
  assign w_req_m = i_req & ~r_grant;

  always_comb begin : p_scan
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(w_base) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && w_req_m[idx]) begin
        w_found = 1'b1;
        w_win   = c_IDX_W'(idx);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;

  assign w_timeout = (r_state == S_GRANT) && !w_end &&
                     (r_hold == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if ((r_state == S_IDLE) || w_drop) begin
        r_hold <= '0;
      end else begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign o_timeout_flag = r_timeout;
`else
  assign w_timeout      = 1'b0;
  assign o_timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_sel    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_owner <= w_win;
            r_grant <= NUM_REQ'(1) << w_win;
            r_sel   <= SEL_W'(w_win) + SEL_W'(1);
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_drop) begin
            r_rr_ptr <= w_next_ptr;
            if (w_found) begin
              r_owner <= w_win;
              r_grant <= NUM_REQ'(1) << w_win;
              r_sel   <= SEL_W'(w_win) + SEL_W'(1);
            end else begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_sel   <= '0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_sel   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant         = r_grant;
  assign o_select_signal = r_sel;
  assign o_bus_busy      = r_busy;

endmodule
`default_nettype wire
